// File: rtl/sfx_pkg.sv
// Shared types and constant tables for the sound-effect sequencer.
// Each requester ID owns one tune in NOTE_ROM starting at TUNE_BASE[id].
package sfx_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    typedef struct packed {
        logic [15:0] half_period;
        logic [7:0]  dur_ms;
    } note_t;

    localparam int unsigned ROM_DEPTH = 64;
    localparam int unsigned NUM_TUNES = 4;

    localparam int unsigned TUNE_BASE [NUM_TUNES] = '{0, 8, 16, 24};

    // Unlisted entries are all-zero, so every tune is terminated by the default.
    localparam note_t NOTE_ROM [ROM_DEPTH] = '{
        0:       '{16'd4, 8'd2},
        8:       '{16'd5, 8'd2},
        16:      '{16'd5, 8'd3},
        24:      '{16'd0, 8'd3},
        25:      '{16'd2, 8'd2},
        default: '{16'd0, 8'd0}
    };

endpackage

// File: rtl/sfx_tone.sv
// Square-wave tone generator: sound toggles every half_period cycles, starting low.
// A zero half_period is a rest and keeps the line low.
module sfx_tone (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] half_period,
    output logic        sound
);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            sound <= 1'b0;
        end else if (start || !enable) begin
            cnt   <= '0;
            sound <= 1'b0;
        end else if (half_period != 16'd0) begin
            if (cnt == half_period - 16'd1) begin
                cnt   <= '0;
                sound <= ~sound;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Priority-arbitrated tune sequencer: walks the note ROM for the winning requester
// and drives the tone child, inserting a silent gap after every note.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned GAP_MS   = 5,
    parameter int unsigned ROM_AW   = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       sound
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t          state_q;
    logic [ROM_AW-1:0] addr_q;
    note_t           rom_q;
    logic [15:0]     hp_q;
    logic [7:0]      ms_cnt;
    logic [TW-1:0]   tick_cnt;

    logic [IDW-1:0]  win_id;
    logic            win_vld;
    logic            accept;
    logic            tick_wrap;
    logic            last_ms;
    logic            tone_en;
    logic            tone_start;

    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                win_id  = IDW'(i);
                win_vld = 1'b1;
            end
        end
    end

    // Outside IDLE only a strictly higher ID may preempt; others are dropped.
    assign accept     = win_vld && ((state_q == IDLE) || (win_id > active_id));
    assign tick_wrap  = (tick_cnt == TW'(TICK_DIV - 1));
    assign last_ms    = tick_wrap && (ms_cnt == 8'd1);
    assign tone_start = (state_q == LOAD);
    assign tone_en    = (state_q == PLAY) && !last_ms && !accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rom_q     <= '0;
            hp_q      <= '0;
            ms_cnt    <= '0;
            tick_cnt  <= '0;
            busy      <= 1'b0;
            active_id <= '0;
            ack       <= '0;
        end else begin
            rom_q <= NOTE_ROM[addr_q];
            ack   <= '0;
            if (accept) begin
                ack[win_id] <= 1'b1;
                active_id   <= win_id;
                busy        <= 1'b1;
                addr_q      <= ROM_AW'(TUNE_BASE[win_id]);
                ms_cnt      <= '0;
                tick_cnt    <= '0;
                state_q     <= FETCH;
            end else begin
                case (state_q)
                    IDLE: ;
                    FETCH: state_q <= LOAD;
                    LOAD: begin
                        if (rom_q.dur_ms == 8'd0) begin
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            hp_q     <= rom_q.half_period;
                            ms_cnt   <= rom_q.dur_ms;
                            tick_cnt <= '0;
                            state_q  <= PLAY;
                        end
                    end
                    PLAY, GAP: begin
                        if (!tick_wrap) begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end else begin
                            tick_cnt <= '0;
                            if (ms_cnt != 8'd1) begin
                                ms_cnt <= ms_cnt - 8'd1;
                            end else if ((state_q == PLAY) && (GAP_MS != 0)) begin
                                ms_cnt  <= 8'(GAP_MS);
                                state_q <= GAP;
                            end else begin
                                ms_cnt  <= '0;
                                addr_q  <= addr_q + ROM_AW'(1);
                                state_q <= FETCH;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    sfx_tone u_tone (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (tone_en),
        .start       (tone_start),
        .half_period (hp_q),
        .sound       (sound)
    );

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with TICK_DIV=10, GAP_MS=1, NUM_REQ=4.
// Tunes: 0={4,2}, 1={5,2}, 2={5,3}, 3={0,3}{2,2}; all single-tune terminated.
module tb_sfx_sequencer;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] active_id;
    logic       sound;

    int total;
    int bad;

    sfx_sequencer #(
        .NUM_REQ  (4),
        .TICK_DIV (10),
        .GAP_MS   (1),
        .ROM_AW   (6)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .ack       (ack),
        .busy      (busy),
        .active_id (active_id),
        .sound     (sound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tone level k cycles into a note of n cycles with half period hp.
    function automatic logic note_sound(input int k, input int hp, input int n);
        if (k < 0 || k >= n || hp == 0) return 1'b0;
        return ((k / hp) % 2) == 1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        repeat (3) tick();
        total++;
        if ({ack, busy, active_id, sound} !== 8'b0) begin
            bad++;
            $display("FAIL reset_state got ack=%b busy=%b id=%0d sound=%b exp all 0",
                     ack, busy, active_id, sound);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        total++;
        if ({ack, busy, sound} !== 6'b0) begin
            bad++;
            $display("FAIL reset_release got ack=%b busy=%b sound=%b exp 0", ack, busy, sound);
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_ack;
        req = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            exp_ack = (c == 1) ? 4'b0001 : 4'b0000;
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("FAIL basic_ack c=%0d got=%b exp=%b", c, ack, exp_ack);
            end
            total++;
            if (busy !== (c <= 34)) begin
                bad++;
                $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, (c <= 34));
            end
            total++;
            if (sound !== note_sound(c - 3, 4, 20)) begin
                bad++;
                $display("FAIL basic_sound c=%0d got=%b exp=%b", c, sound,
                         note_sound(c - 3, 4, 20));
            end
            if (c == 1) begin
                total++;
                if (active_id !== 2'd0) begin
                    bad++;
                    $display("FAIL basic_id got=%0d exp=0", active_id);
                end
            end
        end
    endtask

    task automatic test_rest_lower();
        logic exp_s;
        req = 4'b1000;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            if (c == 10) req = 4'b0100;
            if (c == 30) req = 4'b0000;
            exp_s = note_sound(c - 45, 2, 20);
            total++;
            if (ack !== ((c == 1) ? 4'b1000 : 4'b0000)) begin
                bad++;
                $display("FAIL lower_ack c=%0d got=%b", c, ack);
            end
            total++;
            if (busy !== (c <= 76)) begin
                bad++;
                $display("FAIL rest_busy c=%0d got=%b exp=%b", c, busy, (c <= 76));
            end
            total++;
            if (sound !== exp_s) begin
                bad++;
                $display("FAIL rest_sound c=%0d got=%b exp=%b", c, sound, exp_s);
            end
            if (c <= 76) begin
                total++;
                if (active_id !== 2'd3) begin
                    bad++;
                    $display("FAIL lower_id c=%0d got=%0d exp=3", c, active_id);
                end
            end
        end
    endtask

    task automatic test_preempt();
        logic       exp_s;
        logic [3:0] exp_ack;
        req = 4'b0001;
        for (int c = 1; c <= 48; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            if (c == 10) req = 4'b0010;
            if (c == 11) req = 4'b0000;
            exp_ack = (c == 1) ? 4'b0001 : (c == 11) ? 4'b0010 : 4'b0000;
            exp_s   = (c < 11) ? note_sound(c - 3, 4, 20) : note_sound(c - 13, 5, 20);
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("FAIL preempt_ack c=%0d got=%b exp=%b", c, ack, exp_ack);
            end
            total++;
            if (sound !== exp_s) begin
                bad++;
                $display("FAIL preempt_sound c=%0d got=%b exp=%b", c, sound, exp_s);
            end
            total++;
            if (busy !== (c <= 44)) begin
                bad++;
                $display("FAIL preempt_busy c=%0d got=%b exp=%b", c, busy, (c <= 44));
            end
            if (c >= 11 && c <= 44) begin
                total++;
                if (active_id !== 2'd1) begin
                    bad++;
                    $display("FAIL preempt_id c=%0d got=%0d exp=1", c, active_id);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_s;
        logic [3:0] exp_ack;
        req = 4'b0001;
        for (int c = 1; c <= 72; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            if (c == 34) req = 4'b0010;
            if (c == 35) req = 4'b0000;
            exp_ack = (c == 1) ? 4'b0001 : (c == 35) ? 4'b0010 : 4'b0000;
            exp_s   = (c < 35) ? note_sound(c - 3, 4, 20) : note_sound(c - 37, 5, 20);
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("FAIL b2b_ack c=%0d got=%b exp=%b", c, ack, exp_ack);
            end
            total++;
            if (busy !== (c <= 68)) begin
                bad++;
                $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, (c <= 68));
            end
            total++;
            if (sound !== exp_s) begin
                bad++;
                $display("FAIL b2b_sound c=%0d got=%b exp=%b", c, sound, exp_s);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic       exp_s;
        logic [3:0] exp_ack;
        logic       exp_busy;
        // Held lower request: served once tune2 ends.
        req = 4'b0110;
        for (int c = 1; c <= 84; c++) begin
            tick();
            if (c == 1) req = 4'b0010;
            if (c == 46) req = 4'b0000;
            exp_ack  = (c == 1) ? 4'b0100 : (c == 46) ? 4'b0010 : 4'b0000;
            exp_busy = (c != 45) && (c <= 79);
            exp_s    = (c < 46) ? note_sound(c - 3, 5, 30) : note_sound(c - 48, 5, 20);
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("FAIL simul_ack c=%0d got=%b exp=%b", c, ack, exp_ack);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL simul_busy c=%0d got=%b exp=%b", c, busy, exp_busy);
            end
            total++;
            if (sound !== exp_s) begin
                bad++;
                $display("FAIL simul_sound c=%0d got=%b exp=%b", c, sound, exp_s);
            end
            if (c == 1 || c == 46) begin
                total++;
                if (active_id !== ((c == 1) ? 2'd2 : 2'd1)) begin
                    bad++;
                    $display("FAIL simul_id c=%0d got=%0d", c, active_id);
                end
            end
        end
        // Lower request dropped before tune2 ends: never served.
        req = 4'b0110;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 1) req = 4'b0010;
            if (c == 20) req = 4'b0000;
            total++;
            if (ack !== ((c == 1) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL dropped_ack c=%0d got=%b", c, ack);
            end
            total++;
            if (busy !== (c <= 44)) begin
                bad++;
                $display("FAIL dropped_busy c=%0d got=%b exp=%b", c, busy, (c <= 44));
            end
        end
    endtask

    task automatic test_midplay_reset();
        req = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
        end
        total++;
        if (sound !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL prereset got sound=%b busy=%b exp 1 1", sound, busy);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({ack, busy, active_id, sound} !== 8'b0) begin
            bad++;
            $display("FAIL async_reset got ack=%b busy=%b id=%0d sound=%b exp all 0",
                     ack, busy, active_id, sound);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            total++;
            if ({ack, busy, sound} !== 6'b0) begin
                bad++;
                $display("FAIL post_reset c=%0d got ack=%b busy=%b sound=%b exp 0",
                         c, ack, busy, sound);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        req     = 4'b0000;
        test_reset();
        test_basic();
        repeat (3) tick();
        test_rest_lower();
        repeat (3) tick();
        test_preempt();
        repeat (3) tick();
        test_back_to_back();
        repeat (3) tick();
        test_simultaneous();
        repeat (3) tick();
        test_midplay_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
